conv_pe_scheduler: RTL and testbench

Sequences one convolution layer on the 16-PE cluster.
- Latches a layer configuration on start and steps through output tiles; one tile = one output pixel x 16 output channels.
- Per tile: drives address-generator step requests, delays them by the BRAM read latency into PE_en, pulses PE_finish on the last beat, then waits for the cluster's valid bits before reporting the tile.
- Sits between the host/top-level control and the PE cluster, address generator and weight/IFM BRAMs.

---
 rtl/conv_pe_scheduler.sv | 154 +++++++++++++++
 tb/tb_conv_pe_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_scheduler.sv
// Convolution layer sequencer for the 16-PE cluster: walks output tiles (pixel x 16 channels),
// issues address steps, aligns PE enables to BRAM latency and collects PE valids.
// Optional: `define PE_PARTIAL_GROUP_EN to run a masked partial group when ofm_c % 16 != 0.
module conv_pe_scheduler #(
   parameter int NUM_PE      = 16,
   parameter int MEM_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        cfg_kernel_w,
   input  logic [11:0]       cfg_ifm_c,
   input  logic [11:0]       cfg_ofm_c,
   input  logic [9:0]        cfg_ofm_w,
   input  logic [NUM_PE-1:0] valid,
   output logic              addr_step,
   output logic [NUM_PE-1:0] PE_en,
   output logic [NUM_PE-1:0] PE_finish,
   output logic              tile_done,
   output logic [CNT_W-1:0]  tile_idx,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FLUSH, S_WAIT_V, S_DONE} state_t;

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [2:0]       FL_LAST = 3'(MEM_LATENCY - 1);

   state_t                 state;
   logic [CNT_W-1:0]       beats, tiles, groups, beat_cnt;
   logic [CNT_W-1:0]       beats_c, groups_c, tiles_c;
   logic [2:0]             fl_cnt;
   logic [NUM_PE-1:0]      sticky, active_mask;
   logic [MEM_LATENCY-1:0] step_sr, last_sr;
   logic                   last_step;

   assign beats_c = CNT_W'(cfg_kernel_w) * CNT_W'(cfg_kernel_w) * CNT_W'(cfg_ifm_c[11:2]);
   assign tiles_c = CNT_W'(cfg_ofm_w) * CNT_W'(cfg_ofm_w) * groups_c;

`ifdef PE_PARTIAL_GROUP_EN
   logic [CNT_W-1:0] grp_cnt;
   logic [3:0]       rem_c;

   // Round up so leftover channels get their own, narrower group at the end of each pixel.
   assign groups_c = CNT_W'(({1'b0, cfg_ofm_c} + 13'd15) >> 4);

   always_comb begin
      active_mask = '1;
      if (rem_c != 4'd0 && grp_cnt == groups - ONE)
         active_mask = (NUM_PE'(1) << rem_c) - NUM_PE'(1);
   end
`else
   assign groups_c    = CNT_W'(cfg_ofm_c[11:4]);
   assign active_mask = '1;
`endif

   assign last_step = addr_step && (beat_cnt == beats - ONE);
   assign PE_en     = step_sr[MEM_LATENCY-1] ? active_mask : '0;
   assign PE_finish = last_sr[MEM_LATENCY-1] ? active_mask : '0;
   assign tile_done = (state == S_WAIT_V) && (sticky == active_mask);
   assign busy      = (state == S_ACCUM) || (state == S_FLUSH) || (state == S_WAIT_V);
   assign done      = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         addr_step <= 1'b0;
         beat_cnt  <= '0;
         fl_cnt    <= '0;
         tile_idx  <= '0;
         sticky    <= '0;
         beats     <= '0;
         groups    <= '0;
         tiles     <= '0;
         step_sr   <= '0;
         last_sr   <= '0;
`ifdef PE_PARTIAL_GROUP_EN
         grp_cnt   <= '0;
         rem_c     <= '0;
`endif
      end else begin
         // Delay line models the BRAM read latency between a step and its data at the PEs.
         step_sr[0] <= addr_step;
         last_sr[0] <= last_step;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            step_sr[i] <= step_sr[i-1];
            last_sr[i] <= last_sr[i-1];
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  beats    <= beats_c;
                  groups   <= groups_c;
                  tiles    <= tiles_c;
                  tile_idx <= '0;
                  beat_cnt <= '0;
                  sticky   <= '0;
`ifdef PE_PARTIAL_GROUP_EN
                  grp_cnt  <= '0;
                  rem_c    <= cfg_ofm_c[3:0];
`endif
                  if (beats_c == '0 || tiles_c == '0) begin
                     state <= S_DONE;
                  end else begin
                     state     <= S_ACCUM;
                     addr_step <= 1'b1;
                  end
               end
            end

            S_ACCUM: begin
               if (beat_cnt == beats - ONE) begin
                  addr_step <= 1'b0;
                  fl_cnt    <= '0;
                  state     <= S_FLUSH;
               end else begin
                  beat_cnt <= beat_cnt + ONE;
               end
            end

            S_FLUSH: begin
               if (fl_cnt == FL_LAST) state <= S_WAIT_V;
               else                   fl_cnt <= fl_cnt + 3'd1;
            end

            S_WAIT_V: begin
               if (sticky == active_mask) begin
                  sticky <= '0;
                  if (tile_idx == tiles - ONE) begin
                     state <= S_DONE;
                  end else begin
                     tile_idx  <= tile_idx + ONE;
                     beat_cnt  <= '0;
                     addr_step <= 1'b1;
                     state     <= S_ACCUM;
`ifdef PE_PARTIAL_GROUP_EN
                     grp_cnt   <= (grp_cnt == groups - ONE) ? '0 : grp_cnt + ONE;
`endif
                  end
               end else begin
                  sticky <= sticky | (valid & active_mask);
               end
            end

            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_pe_scheduler.sv
// Directed bench for conv_pe_scheduler (MEM_LATENCY=1); expected timing hand-derived per scenario.
module tb_conv_pe_scheduler;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  cfg_kernel_w;
   logic [11:0] cfg_ifm_c, cfg_ofm_c;
   logic [9:0]  cfg_ofm_w;
   logic [15:0] valid;
   logic        addr_step, tile_done, busy, done;
   logic [15:0] PE_en, PE_finish, tile_idx;

   int n_chk = 0, n_err = 0;
   int cyc = 0;
   int n_step, n_en, n_fin, n_td, n_done, n_bad;
   int first_step, first_en, fin_cyc, td_cyc, done_cyc;
   logic [15:0] fin_val;
   logic [15:0] td_seq [16];

   conv_pe_scheduler #(.NUM_PE(16), .MEM_LATENCY(1), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_kernel_w(cfg_kernel_w), .cfg_ifm_c(cfg_ifm_c), .cfg_ofm_c(cfg_ofm_c),
      .cfg_ofm_w(cfg_ofm_w), .valid(valid),
      .addr_step(addr_step), .PE_en(PE_en), .PE_finish(PE_finish),
      .tile_done(tile_done), .tile_idx(tile_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (addr_step) begin
         if (n_step == 0) first_step = cyc;
         n_step++;
      end
      if (PE_en != 16'h0) begin
         if (n_en == 0) first_en = cyc;
         n_en++;
      end
      if (PE_finish != 16'h0) begin
         n_fin++;
         fin_cyc = cyc;
         fin_val = PE_finish;
         if (PE_en !== PE_finish) n_bad++;
      end
      if (tile_done) begin
         if (n_td < 16) td_seq[n_td] = tile_idx;
         n_td++;
         td_cyc = cyc;
         if (addr_step) n_bad++;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
         if (busy) n_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      n_step = 0; n_en = 0; n_fin = 0; n_td = 0; n_done = 0; n_bad = 0;
      first_step = -1; first_en = -1; fin_cyc = -1; td_cyc = -1; done_cyc = -1;
      fin_val = 16'h0;
   endtask

   task automatic set_cfg(input int k, input int ic, input int oc, input int ow);
      cfg_kernel_w = 4'(k);
      cfg_ifm_c    = 12'(ic);
      cfg_ofm_c    = 12'(oc);
      cfg_ofm_w    = 10'(ow);
   endtask

   task automatic pulse_start(output int s);
      s = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_fin(input int tgt, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 400; i++)
         if (!got) begin
            tick();
            if (n_fin >= tgt) got = 1'b1;
         end
      if (!got) chk(tag, 32'(n_fin), 32'(tgt));
   endtask

   task automatic wait_td(input int tgt, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 400; i++)
         if (!got) begin
            tick();
            if (n_td >= tgt) got = 1'b1;
         end
      if (!got) chk(tag, 32'(n_td), 32'(tgt));
   endtask

   task automatic wait_done(input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 400; i++)
         if (!got) begin
            tick();
            if (n_done > 0) got = 1'b1;
         end
      if (!got) chk(tag, 32'(n_done), 32'd1);
   endtask

   task automatic give_valid(input logic [15:0] v);
      valid = v;
      tick();
      valid = 16'h0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int s;
      reset = 1'b1; start = 1'b0; valid = 16'h0;
      set_cfg(3, 16, 16, 1);
      clr_mon();
      repeat (3) tick();
      chk("rst_out", {addr_step, PE_en, PE_finish, tile_done, busy, done}, 32'h0);
      chk("rst_tidx", 32'(tile_idx), 32'h0);
      reset = 1'b0;
      tick();

      // single tile, 3x3 kernel, 16 ifm channels -> 36 beats
      clr_mon();
      pulse_start(s);
      wait_fin(1, "t1_fin_to");
      repeat (2) tick();
      give_valid(16'hFFFF);
      wait_done("t1_done_to");
      tick();
      chk("t1_steps",   32'(n_step), 32'd36);
      chk("t1_en",      32'(n_en), 32'd36);
      chk("t1_step0",   32'(first_step), 32'(s + 1));
      chk("t1_en0",     32'(first_en), 32'(s + 2));
      chk("t1_fincyc",  32'(fin_cyc), 32'(s + 37));
      chk("t1_finval",  32'(fin_val), 32'hFFFF);
      chk("t1_nfin",    32'(n_fin), 32'd1);
      chk("t1_ntd",     32'(n_td), 32'd1);
      chk("t1_tdcyc",   32'(td_cyc), 32'(s + 41));
      chk("t1_donecyc", 32'(done_cyc), 32'(s + 42));
      chk("t1_busy",    32'(busy), 32'd0);
      chk("t1_bad",     32'(n_bad), 32'd0);

      // 8 tiles: 2x2 pixels x 2 groups, one beat each
      clr_mon();
      set_cfg(1, 4, 32, 2);
      pulse_start(s);
      for (int t = 0; t < 8; t++) begin
         wait_fin(t + 1, "t2_fin_to");
         give_valid(16'hFFFF);
         wait_td(t + 1, "t2_td_to");
      end
      wait_done("t2_done_to");
      chk("t2_steps", 32'(n_step), 32'd8);
      chk("t2_en",    32'(n_en), 32'd8);
      chk("t2_ntd",   32'(n_td), 32'd8);
      chk("t2_ndone", 32'(n_done), 32'd1);
      for (int t = 0; t < 8; t++) chk($sformatf("t2_tidx%0d", t), 32'(td_seq[t]), 32'(t));
      chk("t2_bad",   32'(n_bad), 32'd0);
      tick();

      // split valid; early valid during ACCUM/FLUSH must be ignored
      clr_mon();
      set_cfg(1, 4, 16, 1);
      valid = 16'hFF00;
      pulse_start(s);
      tick();
      tick();
      valid = 16'h0;
      wait_fin(1, "t3_fin_to");
      give_valid(16'h00FF);
      give_valid(16'h00FF);
      repeat (4) tick();
      chk("t3_partial", 32'(n_td), 32'd0);
      s = cyc;
      give_valid(16'hFF00);
      wait_td(1, "t3_td_to");
      chk("t3_tdcyc", 32'(td_cyc), 32'(s + 1));
      wait_done("t3_done_to");
      chk("t3_ntd",   32'(n_td), 32'd1);
      tick();

      // start during ACCUM is ignored
      clr_mon();
      set_cfg(3, 4, 16, 1);
      pulse_start(s);
      repeat (3) tick();
      cfg_kernel_w = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_kernel_w = 4'd3;
      wait_fin(1, "t4_fin_to");
      give_valid(16'hFFFF);
      wait_done("t4_done_to");
      chk("t4_steps", 32'(n_step), 32'd9);
      chk("t4_ntd",   32'(n_td), 32'd1);
      chk("t4_ndone", 32'(n_done), 32'd1);
      repeat (2) tick();

      // zero-size layer goes straight to DONE
      clr_mon();
      set_cfg(3, 16, 16, 0);
      pulse_start(s);
      repeat (3) tick();
      chk("t4z_donecyc", 32'(done_cyc), 32'(s + 1));
      chk("t4z_steps",   32'(n_step), 32'd0);
      chk("t4z_ndone",   32'(n_done), 32'd1);

      // reset mid-ACCUM, then a clean restart
      clr_mon();
      set_cfg(3, 16, 16, 1);
      pulse_start(s);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      chk("t5_rst_out", {addr_step, PE_en, PE_finish, tile_done, busy, done}, 32'h0);
      reset = 1'b0;
      repeat (3) tick();
      chk("t5_nofin",  32'(n_fin + n_done), 32'd0);
      clr_mon();
      set_cfg(1, 4, 16, 1);
      pulse_start(s);
      wait_fin(1, "t5_fin_to");
      give_valid(16'hFFFF);
      wait_done("t5_done_to");
      chk("t5_ntd",  32'(n_td), 32'd1);
      chk("t5_tidx", 32'(td_seq[0]), 32'd0);
      chk("t5_steps", 32'(n_step), 32'd1);
      tick();

      // ofm_c = 20: partial second group when enabled, dropped otherwise
      clr_mon();
      set_cfg(1, 4, 20, 1);
      pulse_start(s);
      wait_fin(1, "t6_fin_to");
      chk("t6_fin0", 32'(fin_val), 32'hFFFF);
      give_valid(16'hFFFF);
      wait_td(1, "t6_td_to");
`ifdef PE_PARTIAL_GROUP_EN
      wait_fin(2, "t6_fin2_to");
      chk("t6_fin1", 32'(fin_val), 32'h000F);
      give_valid(16'hFFF3);
      repeat (3) tick();
      chk("t6_masked_wait", 32'(n_td), 32'd1);
      give_valid(16'h000C);
      wait_td(2, "t6_td2_to");
      wait_done("t6_done_to");
      chk("t6_ntd", 32'(n_td), 32'd2);
      chk("t6_tidx1", 32'(td_seq[1]), 32'd1);
`else
      wait_done("t6_done_to");
      chk("t6_ntd", 32'(n_td), 32'd1);
      chk("t6_steps", 32'(n_step), 32'd1);
`endif
      chk("t6_bad", 32'(n_bad), 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
